inverse_permutation_func: RTL and testbench
===========================================

# inverse_permutation_func

Decoder counterpart of the slice-wise permutation encoder: it applies the inverse of the pi lane permutation to a 64-slice, 25-bit-per-slice state. It fetches lines from an external line memory, decodes each line, and streams the results to a line writer using the same start/done and write-strobe conventions as the encoder. It sits after the encoder in round-trip checks and in the decode path of the matrix pipeline.

## Interface
- No parameters. Slice count is fixed at 64 and line width at 25 bits.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- start  input  1  run request; a run begins on a rising edge of start seen in IDLE.
- rd_addr  output  6  line index presented to the line memory.
- line_in  input  25  line memory data; combinational read of mem[rd_addr], valid in the same cycle.
- write_enable  output  1  one-cycle strobe; write_value/wr_addr are valid while high.
- write_value  output  25  decoded line.
- wr_addr  output  6  index of the decoded line.
- donee  output  1  one-cycle pulse marking the end of a run.

## Operation
- Lane mapping: bit 5*y+x of a line holds lane (x,y), where x,y ∈ 0..4.
- The encoder's forward map is B[x][y] = A[(x+3y) mod 5][x].
- This block computes the inverse: A[x][y] = B[y][(2x+3y) mod 5].
  - Each line is processed independently, with no dependence between slices.
  - The map is pure wiring; there is no arithmetic carry.
- Start edge detection: register start_q <= start each cycle; start_q resets to 0. A run begins when start=1 and start_q=0 in IDLE.
- FSM states and transitions:
  - IDLE: outputs idle. On start rising edge: FETCH, k=0.
  - FETCH: rd_addr=k; capture line_in into line_r at the clock edge. Go to EMIT.
  - EMIT: write_enable=1, write_value=invpi(line_r), wr_addr=k.
    - If k≠63: k=k+1, go to FETCH.
    - If k=63: go to DONE.
  - DONE: donee=1 for exactly one cycle. Go to IDLE.
- k is a 6-bit counter. It never wraps inside a run, because the transition out of EMIT at k=63 goes to DONE.
- Start behaviour:
  - Start edges seen outside IDLE are ignored.
  - Holding start high after a run does not retrigger; start must go low then high again.
- Reset (rst low, asynchronous, including mid-run):
  - State goes to IDLE; k=0, line_r=0, start_q=0.
  - All outputs go to their reset values immediately.
  - The partial run is abandoned; already-issued writes are not retracted.
- Reset value of every output: rd_addr=0, write_enable=0, write_value=0, wr_addr=0, donee=0.

## Timing
- Cycle 0: start rising edge sampled in IDLE.
- Cycle 1: FETCH, rd_addr=0.
- Cycle 2: EMIT line 0.
- In general, line k is fetched in cycle 2k+1 and emitted in cycle 2k+2.
- write_enable alternates 0/1, so every line produces a distinct posedge of write_enable.
- Last write (line 63) is in cycle 128. donee is high in cycle 129. IDLE from cycle 130.
- A new start edge is accepted at the earliest in cycle 130.
- Latency from start edge to first write is 2 cycles; total run length is 129 cycles.
- rd_addr is held at k during both FETCH and EMIT. It changes only on entry to FETCH.
- write_value and wr_addr are registered and hold their last value outside EMIT. Only write_enable qualifies them.

## Test plan
- Single-bit mapping:
  - line 0 = bit 10 only → write 0 = bit 1 only.
  - line 1 = bit 18 only → write 1 = bit 17 only.
  - line 2 = bit 0 → bit 0.
- Round trip:
  - Random 64-line memory passed through the forward-pi model, then this block.
  - All 64 writes must equal the original lines, with wr_addr = 0..63 in order and 64 write_enable posedges.
- Cycle check:
  - Start edge at cycle 0 → write_enable high exactly in even cycles 2..128.
  - donee high only in cycle 129.
  - rd_addr = k in cycles 2k+1 and 2k+2.
- Start held high:
  - start stays 1 for 400 cycles → exactly one run of 64 writes and one donee pulse.
  - Dropping start and raising it again → a second identical run.
- Reset mid-run:
  - Assert rst low during EMIT of line 20 → all outputs 0 immediately, state IDLE, no donee.
  - After release, a fresh start edge → full 64-line run beginning at line 0.
- Reset values and edge patterns:
  - Out of reset with start=1 already high → run begins, since start_q resets to 0.
  - All-zeros memory → 64 zero writes.
  - All-ones memory (25'h1FFFFFF) → 64 all-ones writes.

Source files
------------

// File: rtl/inverse_permutation_func.sv
// rtl/inverse_permutation_func.sv - inverse pi lane permutation over a 64-line, 25-bit state
module inverse_permutation_func (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  rd_addr,
    input  logic [24:0] line_in,
    output logic        write_enable,
    output logic [24:0] write_value,
    output logic [5:0]  wr_addr,
    output logic        donee
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_LINE = 6'd63;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  k_q;
    logic [5:0]  k_d;
    logic [24:0] line_r;
    logic [5:0]  wr_addr_r;
    logic        start_q;
    logic        start_rise;

    // Lane (x,y) sits at bit 5*y+x; A[x][y] = B[y][(2x+3y) mod 5], pure wiring.
    function automatic logic [24:0] inv_pi(input logic [24:0] b);
        logic [24:0] a;
        a = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                a[5*y + x] = b[5*((2*x + 3*y) % 5) + y];
            end
        end
        return a;
    endfunction

    assign start_rise = start & ~start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            line_r    <= '0;
            wr_addr_r <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            start_q <= start;
            // The fetched line and its index stay put until the next fetch.
            if (state_q == S_FETCH) begin
                line_r    <= line_in;
                wr_addr_r <= k_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (k_q == LAST_LINE) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 6'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_addr      = k_q;
        write_enable = (state_q == S_EMIT);
        donee        = (state_q == S_DONE);
        write_value  = inv_pi(line_r);
        wr_addr      = wr_addr_r;
    end

endmodule

// File: tb/tb_inverse_permutation_func.sv
// tb/tb_inverse_permutation_func.sv - scoreboard bench for inverse_permutation_func
module tb_inverse_permutation_func;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  rd_addr;
    logic [24:0] line_in;
    logic        write_enable;
    logic [24:0] write_value;
    logic [5:0]  wr_addr;
    logic        donee;

    logic [24:0] mem[64];
    logic [24:0] exp_line[64];

    typedef struct {
        logic [5:0]  addr;
        logic [24:0] value;
    } wr_t;

    wr_t sb[$];
    wr_t e;
    int  errors = 0;
    int  checks = 0;
    int  we_rise = 0;
    int  done_cnt = 0;
    logic we_prev = 1'b0;

    always #5 clk = ~clk;

    assign line_in = mem[rd_addr];

    inverse_permutation_func dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rd_addr      (rd_addr),
        .line_in      (line_in),
        .write_enable (write_enable),
        .write_value  (write_value),
        .wr_addr      (wr_addr),
        .donee        (donee)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Forward encoder map on a 5x5 lane grid: B[x][y] = A[(x+3y) mod 5][x].
    function automatic logic [24:0] fwd_pi(input logic [24:0] a);
        logic [24:0] b;
        logic        la[5][5];
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                la[x][y] = a[5*y + x];
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                b[5*y + x] = la[(x + 3*y) % 5][x];
        return b;
    endfunction

    task automatic load_random();
        for (int k = 0; k < 64; k++) begin
            exp_line[k] = 25'($urandom());
            mem[k]      = fwd_pi(exp_line[k]);
        end
    endtask

    task automatic load_const(input logic [24:0] v);
        for (int k = 0; k < 64; k++) begin
            exp_line[k] = v;
            mem[k]      = fwd_pi(v);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (write_enable && !we_prev) we_rise++;
            if (donee) done_cnt++;
            if (write_enable) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none at %0t", wr_addr, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("write_value", 32'(write_value), 32'(e.value));
                end
            end
        end
        we_prev = write_enable;
    end

    task automatic push_lines(input int n);
        for (int k = 0; k < n; k++)
            sb.push_back('{addr: 6'(k), value: exp_line[k]});
    endtask

    task automatic run_full(input bit from_reset);
        push_lines(64);
        we_rise  = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        if (from_reset) rst = 1'b1;
        for (int c = 1; c <= 131; c++) begin
            @(negedge clk);
            chk("we_cycle", 32'(write_enable), 32'((c % 2 == 0) && c >= 2 && c <= 128));
            chk("donee_cycle", 32'(donee), 32'(c == 129));
            if (c <= 128) chk("rd_addr", 32'(rd_addr), 32'((c - 1) / 2));
        end
        chk("we_posedges", 32'(we_rise), 32'd64);
        chk("donee_pulses", 32'(done_cnt), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_write_enable"}, 32'(write_enable), 32'd0);
        chk({tag, "_write_value"}, 32'(write_value), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_donee"}, 32'(donee), 32'd0);
    endtask

    initial begin
        load_const(25'd0);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        // Directed single-bit lines, released from reset with start already high.
        load_random();
        mem[0] = 25'h1 << 10; exp_line[0] = 25'h1 << 1;
        mem[1] = 25'h1 << 18; exp_line[1] = 25'h1 << 17;
        mem[2] = 25'h1;       exp_line[2] = 25'h1;
        start = 1'b1;
        run_full(1'b1);
        start = 1'b0;

        load_const(25'd0);
        run_full(1'b0);
        start = 1'b0;

        load_const(25'h1FFFFFF);
        run_full(1'b0);
        start = 1'b0;

        // Start held high for ~400 cycles yields exactly one run.
        load_random();
        run_full(1'b0);
        repeat (270) @(negedge clk);
        chk("hold_we_posedges", 32'(we_rise), 32'd64);
        chk("hold_donee_pulses", 32'(done_cnt), 32'd1);
        chk("hold_sb_empty", 32'(sb.size()), 32'd0);
        start = 1'b0;
        run_full(1'b0);
        start = 1'b0;

        // Reset during EMIT of line 20.
        load_random();
        push_lines(20);
        we_rise  = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (42) @(posedge clk);
        #2;
        chk("mid_we", 32'(write_enable), 32'd1);
        chk("mid_wr_addr", 32'(wr_addr), 32'd20);
        chk("mid_write_value", 32'(write_value), 32'(exp_line[20]));
        rst = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_we_posedges", 32'(we_rise), 32'd20);
        chk("mid_no_donee", 32'(done_cnt), 32'd0);
        chk("mid_sb_drained", 32'(sb.size()), 32'd0);
        chk("mid_idle_we", 32'(write_enable), 32'd0);
        load_random();
        run_full(1'b0);
        start = 1'b0;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
